// File: rtl/pid_pwm_stage_pkg.sv
// -----------------------------------------------------------------------------
// pid_pwm_stage_pkg
// Shared constants and types for the PID actuator PWM stage.
//   N     : width of the signed controller word
//   Q     : fractional bits of the controller word (1.0 == 1 << Q)
//   ONE   : fixed-point 1.0
//   PERIOD_DEF / CW_DEF : default PWM period and counter width
//   pwm_state_e : run-control FSM encoding
// -----------------------------------------------------------------------------
package pid_pwm_stage_pkg;

    localparam int N          = 32;
    localparam int Q          = 18;
    localparam int PERIOD_DEF = 1000;
    localparam int CW_DEF     = 10;

    localparam logic [N-1:0] ONE = N'(1) << Q;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pid_pwm_stage_if.sv
// -----------------------------------------------------------------------------
// pid_pwm_stage_if
// Bundles the controller-side command inputs and the actuator-side outputs
// of the PWM stage.
//   master : drives data_in/data_valid/enable, observes the PWM outputs
//   slave  : the PWM stage itself
// -----------------------------------------------------------------------------
interface pid_pwm_stage_if #(
    parameter int N  = pid_pwm_stage_pkg::N,
    parameter int CW = pid_pwm_stage_pkg::CW_DEF
) ();

    logic [N-1:0]  data_in;
    logic          data_valid;
    logic          enable;
    logic          pwm_out;
    logic          dir_out;
    logic          sat_flag;
    logic [CW-1:0] duty_out;
    logic          period_start;

    modport master (
        output data_in, data_valid, enable,
        input  pwm_out, dir_out, sat_flag, duty_out, period_start
    );

    modport slave (
        input  data_in, data_valid, enable,
        output pwm_out, dir_out, sat_flag, duty_out, period_start
    );

endinterface

// File: rtl/pid_pwm_stage_duty_calc.sv
// -----------------------------------------------------------------------------
// pwm_duty_calc
// Combinational conversion of a signed Qx controller word into a PWM command:
// clamp to [-1.0, +1.0], take the magnitude, scale by PERIOD.
//   data_i : signed fixed-point controller output
//   duty_o : (|clamped| * PERIOD) >> Q, truncated, 0..PERIOD
//   dir_o  : sign of the raw input (1 = negative)
//   sat_o  : clamp changed the value
// -----------------------------------------------------------------------------
module pwm_duty_calc #(
    parameter int N      = pid_pwm_stage_pkg::N,
    parameter int Q      = pid_pwm_stage_pkg::Q,
    parameter int PERIOD = pid_pwm_stage_pkg::PERIOD_DEF,
    parameter int CW     = pid_pwm_stage_pkg::CW_DEF
) (
    input  logic [N-1:0]  data_i,
    output logic [CW-1:0] duty_o,
    output logic          dir_o,
    output logic          sat_o
);

    localparam int                  PW      = Q + 1 + CW;
    localparam logic signed [N-1:0] POS_ONE = N'(1) << Q;
    localparam logic signed [N-1:0] NEG_ONE = -POS_ONE;

    logic signed [N-1:0] din_s;
    logic signed [N-1:0] clamp_s;
    logic [Q:0]          mag_s;
    logic [PW-1:0]       prod_s;

    // Clamp in the signed domain, then magnitude and scale to a duty count.
    always_comb begin
        din_s = signed'(data_i);
        if (din_s > POS_ONE) begin
            clamp_s = POS_ONE;
            sat_o   = 1'b1;
        end else if (din_s < NEG_ONE) begin
            clamp_s = NEG_ONE;
            sat_o   = 1'b1;
        end else begin
            clamp_s = din_s;
            sat_o   = 1'b0;
        end

        // Clamped value is within +-2^Q, so the magnitude always fits Q+1 bits
        // (the most negative input was already clamped, no abs overflow).
        if (clamp_s[N-1]) begin
            mag_s = (Q+1)'(-clamp_s);
        end else begin
            mag_s = (Q+1)'(clamp_s);
        end

        prod_s = PW'(mag_s) * PW'(PERIOD);
        duty_o = CW'(prod_s >> Q);
        dir_o  = data_i[N-1];
    end

endmodule

// File: rtl/pid_pwm_stage.sv
// -----------------------------------------------------------------------------
// pid_pwm_stage
// Actuator stage for the fixed-point PID controller. Each data_valid strobe
// converts the controller word into {duty, dir, sat} and stores it in a pending
// register; the pending command becomes active only at a PWM period boundary
// (counter wrap or IDLE->RUN) so the waveform never changes mid-period.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low, clears all state
//   bus    : slave side of pid_pwm_stage_if
//            in : data_in, data_valid, enable
//            out: pwm_out, dir_out, sat_flag, duty_out, period_start
// -----------------------------------------------------------------------------
module pid_pwm_stage #(
    parameter int N      = pid_pwm_stage_pkg::N,
    parameter int Q      = pid_pwm_stage_pkg::Q,
    parameter int PERIOD = pid_pwm_stage_pkg::PERIOD_DEF,
    parameter int CW     = pid_pwm_stage_pkg::CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    pid_pwm_stage_if.slave bus
);

    import pid_pwm_stage_pkg::*;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] calc_duty_s;
    logic          calc_dir_s;
    logic          calc_sat_s;

    pwm_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pend_duty_q, pend_duty_d;
    logic          pend_dir_q, pend_dir_d;
    logic          pend_sat_q, pend_sat_d;
    logic [CW-1:0] act_duty_q, act_duty_d;
    logic          act_dir_q, act_dir_d;
    logic          act_sat_q, act_sat_d;
    logic          pwm_q, pwm_d;
    logic          pstart_q, pstart_d;
    logic          run_s;

    pwm_duty_calc #(
        .N      (N),
        .Q      (Q),
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_duty_calc (
        .data_i (bus.data_in),
        .duty_o (calc_duty_s),
        .dir_o  (calc_dir_s),
        .sat_o  (calc_sat_s)
    );

    // Next-state: pending capture, FSM, counter, active load, output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        pend_sat_d  = pend_sat_q;
        act_duty_d  = act_duty_q;
        act_dir_d   = act_dir_q;
        act_sat_d   = act_sat_q;
        run_s       = 1'b0;
        pwm_d       = 1'b0;
        pstart_d    = 1'b0;

        // Pending keeps tracking the controller in every state; last valid wins.
        if (bus.data_valid) begin
            pend_duty_d = calc_duty_s;
            pend_dir_d  = calc_dir_s;
            pend_sat_d  = calc_sat_s;
        end else begin
            pend_duty_d = pend_duty_q;
            pend_dir_d  = pend_dir_q;
            pend_sat_d  = pend_sat_q;
        end

        // Active always loads from the OLD pending value, so a valid on the
        // boundary edge lands one period later.
        case (state_q)
            ST_IDLE: begin
                cnt_d = CW'(0);
                if (bus.enable) begin
                    state_d    = ST_RUN;
                    act_duty_d = pend_duty_q;
                    act_dir_d  = pend_dir_q;
                    act_sat_d  = pend_sat_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = CW'(0);
                    act_duty_d = pend_duty_q;
                    act_dir_d  = pend_dir_q;
                    act_sat_d  = pend_sat_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Disable wins over the counter but not over the active load.
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = CW'(0);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CW'(0);
            end
        endcase

        // Outputs are decoded from next-state so they register in step with cnt.
        run_s = (state_d == ST_RUN);
        if (run_s) begin
            pwm_d    = (cnt_d < act_duty_d);
            pstart_d = (cnt_d == CW'(0));
        end else begin
            pwm_d    = 1'b0;
            pstart_d = 1'b0;
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CW'(0);
            pend_duty_q <= CW'(0);
            pend_dir_q  <= 1'b0;
            pend_sat_q  <= 1'b0;
            act_duty_q  <= CW'(0);
            act_dir_q   <= 1'b0;
            act_sat_q   <= 1'b0;
            pwm_q       <= 1'b0;
            pstart_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            pend_sat_q  <= pend_sat_d;
            act_duty_q  <= act_duty_d;
            act_dir_q   <= act_dir_d;
            act_sat_q   <= act_sat_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = pstart_q;
    assign bus.duty_out     = act_duty_q;
    assign bus.dir_out      = act_dir_q;
    assign bus.sat_flag     = act_sat_q;

endmodule

// File: tb/tb_pid_pwm_stage.sv
// -----------------------------------------------------------------------------
// tb_pid_pwm_stage
// Directed stimulus pushes the expected {duty, dir, sat} of each upcoming PWM
// period into a scoreboard queue; an independent monitor pops one entry per
// period_start and checks the header plus the PWM shape over the period.
// -----------------------------------------------------------------------------
module tb_pid_pwm_stage;

    localparam int PERIOD = 1000;
    localparam int CW     = 10;
    localparam int N      = 32;

    typedef struct packed {
        logic [CW-1:0] duty;
        logic          dir;
        logic          sat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   pos;
    bit   abort_req;
    exp_t sb_q[$];

    pid_pwm_stage_if #(.N(N), .CW(CW)) bus ();

    pid_pwm_stage #(.N(N), .Q(18), .PERIOD(PERIOD), .CW(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int duty, input bit dir, input bit sat);
        exp_t e;
        e.duty = CW'(duty);
        e.dir  = dir;
        e.sat  = sat;
        return e;
    endfunction

    task automatic go_to(input int k);
        if (k > pos) begin
            repeat (k - pos) @(negedge clk);
        end
        pos = k;
    endtask

    task automatic send(input logic [N-1:0] v);
        bus.data_in    = v;
        bus.data_valid = 1'b1;
        @(negedge clk);
        pos++;
        bus.data_valid = 1'b0;
    endtask

    task automatic sync_period();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.period_start && k < 2 * PERIOD);
        check("sync_period_start", bus.period_start, 1);
        pos = 0;
    endtask

    // Monitor: one scoreboard entry per period; checks header and PWM shape.
    initial begin : monitor
        exp_t cur;
        int   idx;
        int   high;
        int   bad;
        bit   in_p;
        in_p = 1'b0;
        idx  = 0;
        high = 0;
        bad  = 0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (abort_req) begin
                if (in_p) begin
                    check("pwm_shape_partial", bad, 0);
                    in_p = 1'b0;
                end
            end else if (bus.period_start) begin
                if (in_p) begin
                    check("pwm_shape_partial", bad, 0);
                    in_p = 1'b0;
                end
                if (sb_q.size() == 0) begin
                    check("scoreboard_has_entry", sb_q.size(), 1);
                end else begin
                    cur = sb_q.pop_front();
                    check("period_duty", bus.duty_out, cur.duty);
                    check("period_dir_sat", {bus.dir_out, bus.sat_flag}, {cur.dir, cur.sat});
                    in_p = 1'b1;
                    idx  = 0;
                    high = 0;
                    bad  = 0;
                end
            end else if (in_p) begin
                idx++;
            end
            if (in_p && !abort_req) begin
                if (bus.pwm_out) high++;
                if (bus.pwm_out != (idx < int'(cur.duty))) bad++;
                if (idx == PERIOD - 1) begin
                    check("pwm_shape", bad, 0);
                    check("pwm_high_cycles", high, cur.duty);
                    in_p = 1'b0;
                end
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin : stimulus
        clk            = 1'b0;
        rst_n          = 1'b0;
        n_total        = 0;
        n_pass         = 0;
        pos            = 0;
        abort_req      = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.enable     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_pwm", bus.pwm_out, 0);
        check("rst_dir", bus.dir_out, 0);
        check("rst_sat", bus.sat_flag, 0);
        check("rst_duty", bus.duty_out, 0);
        check("rst_pstart", bus.period_start, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0.5 loaded while idle: pending only, active untouched.
        send(32'h0002_0000);
        check("idle_active_hold", bus.duty_out, 0);
        sb_q.push_back(mk(500, 1'b0, 1'b0));
        bus.enable = 1'b1;
        @(negedge clk);
        check("enable_pstart", bus.period_start, 1);
        check("enable_pwm_first", bus.pwm_out, 1);
        pos = 0;

        // -0.25
        go_to(10); send(32'hFFFF_0000); sb_q.push_back(mk(250, 1'b1, 1'b0)); sync_period();
        // +4.0 saturates high
        go_to(10); send(32'h0010_0000); sb_q.push_back(mk(1000, 1'b0, 1'b1)); sync_period();
        // most negative word saturates to -1.0
        go_to(10); send(32'h8000_0000); sb_q.push_back(mk(1000, 1'b1, 1'b1)); sync_period();
        // zero
        go_to(10); send(32'h0000_0000); sb_q.push_back(mk(0, 1'b0, 1'b0)); sync_period();
        // mid-period 0.1 (26215/2^18) at cnt 300: this period stays 0
        go_to(300); send(32'h0000_6667); sb_q.push_back(mk(100, 1'b0, 1'b0)); sync_period();
        // 0.2 then 0.7 in one period: last wins
        go_to(100); send(32'h0000_CCCD);
        go_to(600); send(32'h0002_CCCD);
        sb_q.push_back(mk(700, 1'b0, 1'b0)); sync_period();
        // valid on the wrap edge: one extra period of the old duty
        sb_q.push_back(mk(700, 1'b0, 1'b0));
        go_to(999); send(32'h0002_0000);
        check("wrap_edge_pstart", bus.period_start, 1);
        pos = 0;
        sb_q.push_back(mk(500, 1'b0, 1'b0)); sync_period();

        // Disable at cnt 400 while pwm is high.
        go_to(400);
        bus.enable = 1'b0;
        abort_req  = 1'b1;
        @(negedge clk);
        check("disable_pwm_low", bus.pwm_out, 0);
        check("disable_pstart_low", bus.period_start, 0);
        check("disable_duty_hold", bus.duty_out, 500);
        repeat (2) @(negedge clk);
        abort_req = 1'b0;
        send(32'hFFFF_0000);
        check("idle_pending_only_duty", bus.duty_out, 500);
        check("idle_pending_only_dir", bus.dir_out, 0);
        sb_q.push_back(mk(250, 1'b1, 1'b0));
        bus.enable = 1'b1;
        @(negedge clk);
        check("reenable_pstart", bus.period_start, 1);
        pos = 0;

        // Asynchronous reset in the middle of the high pulse.
        go_to(100);
        check("pre_reset_pwm_high", bus.pwm_out, 1);
        #2;
        rst_n     = 1'b0;
        abort_req = 1'b1;
        #1;
        check("async_rst_pwm", bus.pwm_out, 0);
        check("async_rst_dir", bus.dir_out, 0);
        check("async_rst_duty", bus.duty_out, 0);
        check("async_rst_pstart", bus.period_start, 0);
        @(negedge clk);
        @(negedge clk);
        abort_req = 1'b0;
        sb_q.push_back(mk(0, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_pstart", bus.period_start, 1);
        check("post_reset_duty", bus.duty_out, 0);
        pos = 0;

        // Disable exactly on the wrap: active still loads the pending 0.5.
        go_to(50); send(32'h0002_0000);
        go_to(999);
        bus.enable = 1'b0;
        @(negedge clk);
        check("wrap_disable_duty_load", bus.duty_out, 500);
        check("wrap_disable_pwm", bus.pwm_out, 0);
        check("wrap_disable_pstart", bus.period_start, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pid_pwm_stage.md
# pid_pwm_stage

Downstream actuator stage for the fixed-point PID controller. It accepts the signed Q18 controller output and clamps it to ±1.0. It converts the magnitude to a duty count and drives a single-ended PWM output plus a direction bit. New duty values take effect only at PWM period boundaries, so the waveform never glitches mid-period.

## Interface
Parameters:
- `N`, 32, data width of controller output
- `Q`, 18, fractional bits; 1.0 = `1 << Q`
- `PERIOD`, 1000, PWM period in clk cycles; 2 ≤ PERIOD < 2^CW
- `CW`, 10, counter/duty width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `data_in`  in  N  signed Q18 controller output
- `data_valid`  in  1  one-cycle strobe qualifying `data_in`
- `enable`  in  1  run PWM when high
- `pwm_out`  out  1  PWM waveform
- `dir_out`  out  1  1 = negative command
- `sat_flag`  out  1  active command was clamped
- `duty_out`  out  CW  active duty count, 0..PERIOD
- `period_start`  out  1  high for the cycle in which `cnt == 0` while running

## Operation
- Clamp, in the signed domain, to [-ONE, +ONE], where ONE = 2^Q.
  - 0x8000_0000 clamps to -ONE. There is no abs overflow.
- Magnitude: `m = |clamped|`, 0..2^Q (Q+1 bits).
- Duty: `(m * PERIOD) >> Q`, truncated, range 0..PERIOD. Use a (Q+1+CW)-bit product.
- Direction: `dir = data_in[N-1]`. A zero input gives dir 0.
- Sat: set when the clamp changed the value.
- Pending register: {duty, dir, sat} is loaded on the edge after `data_valid`. Several valids in one period: the last one wins.
- Active register: loaded from pending on the edge where `cnt` wraps PERIOD-1 → 0, and on the IDLE → RUN edge.
- Registered outputs:
  - `pwm_out = (cnt < duty_active)`. Duty PERIOD means constantly high; duty 0 means constantly low.
  - `dir_out`, `sat_flag` and `duty_out` reflect the active register.
- FSM:
  - IDLE: `cnt` = 0; `pwm_out` and `period_start` are 0. `dir_out`, `sat_flag` and `duty_out` hold their last active values. The pending register keeps updating. Move to RUN when `enable` = 1.
  - RUN: `cnt` increments and wraps at PERIOD-1. Move to IDLE when `enable` = 0, effective the next edge: `pwm_out` goes 0 and `cnt` goes 0.

## Timing
- Reset values: `pwm_out`, `dir_out`, `sat_flag`, `duty_out`, `period_start` = 0. Counter, pending and active registers = 0. State = IDLE.
- Reset mid-operation clears everything asynchronously. The first PWM edge follows reset release, then `enable`.
- Latency, valid → pending: 1 cycle.
- Latency, pending → output:
  - A valid in a cycle with `cnt ≤ PERIOD-2` appears in the next period.
  - A valid when `cnt == PERIOD-1` appears one period later.
- `enable` rising in cycle t: RUN, `cnt` = 0, active loaded, `period_start` = 1 at t+1. `pwm_out` is high at t+1 if duty > 0.
- `data_valid` coinciding with the wrap edge: active takes the old pending value; pending takes the new value.
- `enable` low on the same cycle as a wrap: go to IDLE, but the active register is still loaded.

## Structure
- Shared package holds:
  - `Q`, `N`
  - `ONE = 1 << Q`
  - the FSM state encoding (IDLE, RUN)
- One sub-module, `pwm_duty_calc`: combinational clamp, abs and scale, producing {duty, dir, sat}. Reusable by other actuator stages.
- The top level holds the pending/active registers, counter and FSM.

## Test plan
- 0.5 (0x0002_0000), valid, then enable → `duty_out` 500; `pwm_out` high for cnt 0..499, low for 500..999; `dir_out` 0; `sat_flag` 0.
- -0.25 (0xFFFF_0000) → duty 250, `dir_out` 1, `sat_flag` 0.
- Saturation:
  - 4.0 (0x0010_0000) → duty 1000, `pwm_out` constantly high, `sat_flag` 1.
  - 0x8000_0000 → duty 1000, dir 1, sat 1.
  - 0 → duty 0, `pwm_out` constantly low.
- Mid-period updates:
  - At cnt = 300, valid 0.1 → current period unchanged; next period duty 100.
  - Two valids in one period (0.2 then 0.7) → duty 700.
  - Valid at cnt = 999 → applied one period later.
- `enable` dropped at cnt = 400 → `pwm_out` 0 and `cnt` 0 next cycle. Re-enable → `period_start` pulse after 1 cycle; PWM resumes with the latest pending duty.
- `reset` asserted mid-high pulse → all outputs 0 immediately, without waiting for a clock edge. After release plus enable, duty = 0 until a new valid arrives.
